// File: rtl/inst_sram_resp_pkg.sv
// Shared CPU header for the instruction SRAM responder.
// Holds bus-width defines, default memory map values, and the word-index helper.
package inst_sram_resp_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEN_W  = DATA_W / 8;

  // Reset vector region: byte address of word 0 and array size in words (log2)
  localparam logic [ADDR_W-1:0] ADDR_BASE_DEFAULT  = 32'hbfc00000;
  localparam int                DEPTH_LOG2_DEFAULT = 14;

  // Word offset from the base, modulo 2^30. Byte offset bits never take part.
  function automatic logic [ADDR_W-3:0] word_index(
    input logic [ADDR_W-3:0] word_addr,
    input logic [ADDR_W-3:0] base_word
  );
    return word_addr - base_word;
  endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// Instruction SRAM bus: request (en/wen/addr/wdata) from the initiator,
// registered read data back from the memory.
//   master : initiator side (drives the request, receives rdata)
//   slave  : memory side (receives the request, drives rdata)
interface inst_sram_resp_if
  import inst_sram_resp_pkg::*;
;
  logic              inst_sram_en;
  logic [WEN_W-1:0]  inst_sram_wen;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_wdata;
  logic [DATA_W-1:0] inst_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata
  );

endinterface

// File: rtl/inst_sram_resp_sram_array.sv
// Single-port storage: byte-write, synchronous read, read-first.
// Ports:
//   clk   - clock
//   en    - access strobe; rdata only updates when asserted
//   wen   - per-byte write enables (lane i -> bits [8i+7:8i])
//   addr  - word address
//   wdata - write data
//   rdata - word as it was before this edge's write
// Contents have no reset.
module sram_array
  import inst_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WEN_W-1:0]      wen,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < WEN_W; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: fixed one-cycle-latency memory on the
// instruction bus, with range decode, an out-of-range error flag, and a read counter.
// Ports:
//   clk     - clock
//   reset   - synchronous, active-high
//   bus     - instruction SRAM bus (slave side)
//   oor_err - sticky out-of-range access flag, cleared only by reset
//   rd_cnt  - count of accepted in-range reads (wraps)
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_BASE  = ADDR_BASE_DEFAULT,
  parameter int                DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  inst_sram_resp_if.slave    bus,
  output logic               oor_err,
  output logic [DATA_W-1:0]  rd_cnt
);

  logic [ADDR_W-3:0] word_idx;
  logic              in_range;
  logic              is_read;
  logic              array_en;
  logic [DATA_W-1:0] array_rdata;
  logic              zero_q;
  logic              unused_addr_lo;

  assign unused_addr_lo = ^bus.inst_sram_addr[1:0];

  assign word_idx = word_index(bus.inst_sram_addr[ADDR_W-1:2], ADDR_BASE[ADDR_W-1:2]);
  assign in_range = (word_idx >> DEPTH_LOG2) == '0;
  assign is_read  = bus.inst_sram_wen == '0;
  // Requests made during reset must not reach the storage.
  assign array_en = bus.inst_sram_en && in_range && !reset;

  sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .en    (array_en),
    .wen   (bus.inst_sram_wen),
    .addr  (word_idx[DEPTH_LOG2-1:0]),
    .wdata (bus.inst_sram_wdata),
    .rdata (array_rdata)
  );

  // The array output register holds when not enabled, so idle cycles hold
  // rdata automatically. zero_q masks it after reset or an out-of-range
  // access until the next in-range access reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q  <= 1'b1;
      oor_err <= 1'b0;
      rd_cnt  <= '0;
    end else if (bus.inst_sram_en) begin
      zero_q <= !in_range;
      if (!in_range) oor_err <= 1'b1;
      if (in_range && is_read) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  assign bus.inst_sram_rdata = zero_q ? '0 : array_rdata;

endmodule
